// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - ALU execute stage with operand forwarding and a 16-cycle shift-add multiplier
module execute_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [3:0]  op,
  input  logic [2:0]  src_a_addr,
  input  logic [2:0]  src_b_addr,
  input  logic [15:0] reg_a_data,
  input  logic [15:0] reg_b_data,
  input  logic        use_imm,
  input  logic [15:0] imm,
  input  logic [2:0]  writeback_address_in,
  input  logic        writeback_en_in,
  input  logic        writeback_src_in,
  input  logic        we_in,
  input  logic [2:0]  wb_address,
  input  logic        wb_en,
  input  logic [15:0] wb_data,
  output logic [2:0]  writeback_address_out,
  output logic        writeback_en_out,
  output logic        writeback_src_out,
  output logic [15:0] alu_data_out,
  output logic [15:0] store_data_out,
  output logic        we_out,
  output logic        zero_out,
  output logic        stall
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;

  typedef enum logic {IDLE, MUL} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [15:0] mcand_q, mplier_q, store_q, prod_q, prod_d;
  logic [2:0]  wa_q;
  logic        wen_q, wsrc_q, we_q;

  logic        own_fwd;
  logic [15:0] op_a, raw_b, op_b, alu_res;

  // Own-output forwarding only applies to ALU results; loads are resolved upstream.
  assign own_fwd = writeback_en_out && !writeback_src_out;

  always_comb begin
    op_a = reg_a_data;
    if (own_fwd && writeback_address_out == src_a_addr) op_a = alu_data_out;
    else if (wb_en && wb_address == src_a_addr)        op_a = wb_data;

    raw_b = reg_b_data;
    if (own_fwd && writeback_address_out == src_b_addr) raw_b = alu_data_out;
    else if (wb_en && wb_address == src_b_addr)        raw_b = wb_data;

    op_b = use_imm ? imm : raw_b;

    case (op)
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_SHL:  alu_res = op_a << op_b[3:0];
      OP_SHR:  alu_res = op_a >> op_b[3:0];
      OP_SLT:  alu_res = {15'd0, $signed(op_a) < $signed(op_b)};
      default: alu_res = op_b;
    endcase
  end

  assign prod_d = mplier_q[cnt_q] ? prod_q + (mcand_q << cnt_q) : prod_q;

  always_comb begin
    stall = 1'b0;
    if (state_q == IDLE) stall = valid_in && (op == OP_MUL);
    else                 stall = (cnt_q != 4'd15);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q               <= IDLE;
      cnt_q                 <= 4'd0;
      mcand_q               <= 16'd0;
      mplier_q              <= 16'd0;
      store_q               <= 16'd0;
      prod_q                <= 16'd0;
      wa_q                  <= 3'd0;
      wen_q                 <= 1'b0;
      wsrc_q                <= 1'b0;
      we_q                  <= 1'b0;
      writeback_address_out <= 3'd0;
      writeback_en_out      <= 1'b0;
      writeback_src_out     <= 1'b0;
      alu_data_out          <= 16'd0;
      store_data_out        <= 16'd0;
      we_out                <= 1'b0;
      zero_out              <= 1'b1;
    end else begin
      // Bubble unless a result is retired this edge.
      writeback_address_out <= 3'd0;
      writeback_en_out      <= 1'b0;
      writeback_src_out     <= 1'b0;
      alu_data_out          <= 16'd0;
      store_data_out        <= 16'd0;
      we_out                <= 1'b0;
      zero_out              <= 1'b1;

      if (state_q == IDLE) begin
        if (valid_in && op == OP_MUL) begin
          state_q  <= MUL;
          cnt_q    <= 4'd0;
          prod_q   <= 16'd0;
          mcand_q  <= op_a;
          mplier_q <= op_b;
          store_q  <= raw_b;
          wa_q     <= writeback_address_in;
          wen_q    <= writeback_en_in;
          wsrc_q   <= writeback_src_in;
          we_q     <= we_in;
        end else if (valid_in) begin
          writeback_address_out <= writeback_address_in;
          writeback_en_out      <= writeback_en_in;
          writeback_src_out     <= writeback_src_in;
          alu_data_out          <= alu_res;
          store_data_out        <= raw_b;
          we_out                <= we_in;
          zero_out              <= (alu_res == 16'd0);
        end
      end else begin
        prod_q <= prod_d;
        cnt_q  <= cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_q               <= IDLE;
          writeback_address_out <= wa_q;
          writeback_en_out      <= wen_q;
          writeback_src_out     <= wsrc_q;
          alu_data_out          <= prod_d;
          store_data_out        <= store_q;
          we_out                <= we_q;
          zero_out              <= (prod_d == 16'd0);
        end
      end
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - self-checking bench for execute_stage against an arithmetic reference model
module tb_execute_stage;

  logic        clk, rst, valid_in, use_imm, writeback_en_in, writeback_src_in, we_in, wb_en;
  logic [3:0]  op;
  logic [2:0]  src_a_addr, src_b_addr, writeback_address_in, wb_address;
  logic [15:0] reg_a_data, reg_b_data, imm, wb_data;
  logic [2:0]  writeback_address_out;
  logic        writeback_en_out, writeback_src_out, we_out, zero_out, stall;
  logic [15:0] alu_data_out, store_data_out;

  execute_stage dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .op(op),
    .src_a_addr(src_a_addr), .src_b_addr(src_b_addr),
    .reg_a_data(reg_a_data), .reg_b_data(reg_b_data),
    .use_imm(use_imm), .imm(imm),
    .writeback_address_in(writeback_address_in), .writeback_en_in(writeback_en_in),
    .writeback_src_in(writeback_src_in), .we_in(we_in),
    .wb_address(wb_address), .wb_en(wb_en), .wb_data(wb_data),
    .writeback_address_out(writeback_address_out), .writeback_en_out(writeback_en_out),
    .writeback_src_out(writeback_src_out), .alu_data_out(alu_data_out),
    .store_data_out(store_data_out), .we_out(we_out), .zero_out(zero_out), .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected architectural outputs of the stage
  logic        m_en, m_src, m_we, m_zero;
  logic [2:0]  m_addr;
  logic [15:0] m_alu, m_store;
  int          stall_cycles;
  logic        bubble_bad;

  logic [38:0] dut_vec;
  assign dut_vec = {writeback_en_out, writeback_src_out, writeback_address_out,
                    alu_data_out, store_data_out, we_out, zero_out};

  function automatic logic [38:0] exp_vec();
    return {m_en, m_src, m_addr, m_alu, m_store, m_we, m_zero};
  endfunction

  task automatic model_reset();
    m_en = 0; m_src = 0; m_addr = 0; m_alu = 0; m_store = 0; m_we = 0; m_zero = 1;
  endtask

  function automatic logic [15:0] ref_fwd(input logic [2:0] s, input logic [15:0] r);
    if (m_en && !m_src && m_addr == s) return m_alu;
    if (wb_en && wb_address == s) return wb_data;
    return r;
  endfunction

  function automatic logic [15:0] ref_alu(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b);
    int unsigned ua, ub, r;
    int sa, sb;
    ua = a; ub = b;
    sa = (ua >= 32768) ? int'(ua) - 65536 : int'(ua);
    sb = (ub >= 32768) ? int'(ub) - 65536 : int'(ub);
    case (o)
      4'd0: r = ua + ub;
      4'd1: r = ua - ub;
      4'd2: r = ua & ub;
      4'd3: r = ua | ub;
      4'd4: r = ua ^ ub;
      4'd5: r = ua * (32'd1 << (ub % 16));
      4'd6: r = ua / (32'd1 << (ub % 16));
      4'd7: r = (sa < sb) ? 1 : 0;
      4'd8: r = ua * ub;
      default: r = ub;
    endcase
    return r[15:0];
  endfunction

  // Presents one instruction, holds it through any stall, and advances the model.
  task automatic issue(input logic v, input logic [3:0] o, input logic [2:0] sa, input logic [2:0] sb,
                       input logic [15:0] ra, input logic [15:0] rb, input logic ui, input logic [15:0] im,
                       input logic [2:0] wa, input logic wen, input logic wsrc, input logic wei);
    logic [15:0] a, rawb, b, res;
    valid_in = v; op = o; src_a_addr = sa; src_b_addr = sb; reg_a_data = ra; reg_b_data = rb;
    use_imm = ui; imm = im; writeback_address_in = wa; writeback_en_in = wen;
    writeback_src_in = wsrc; we_in = wei;
    #1;
    a = ref_fwd(sa, ra);
    rawb = ref_fwd(sb, rb);
    b = ui ? im : rawb;
    res = ref_alu(o, a, b);
    stall_cycles = 0;
    bubble_bad = 0;
    while (stall === 1'b1 && stall_cycles < 40) begin
      @(posedge clk); #1;
      stall_cycles++;
      if (dut_vec !== 39'd1) bubble_bad = 1;
    end
    if (stall_cycles < 40) begin
      @(posedge clk); #1;
    end
    if (v) begin
      m_en = wen; m_src = wsrc; m_addr = wa; m_alu = res; m_store = rawb; m_we = wei; m_zero = (res == 16'd0);
    end else begin
      model_reset();
    end
    valid_in = 0;
  endtask

  task automatic test_reset();
    rst = 1; valid_in = 0; op = 0; src_a_addr = 0; src_b_addr = 0; reg_a_data = 0; reg_b_data = 0;
    use_imm = 0; imm = 0; writeback_address_in = 0; writeback_en_in = 0; writeback_src_in = 0;
    we_in = 0; wb_address = 0; wb_en = 0; wb_data = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (dut_vec !== 39'd1) begin errors++; $display("FAIL reset_outputs: got %h expected %h", dut_vec, 39'd1); end
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
    rst = 0;
    model_reset();
  endtask

  task automatic test_alu_basic();
    issue(1, 4'd0, 3'd4, 3'd5, 16'h7FFF, 16'h0001, 0, 16'h0, 3'd3, 1, 0, 0);
    checks++;
    if (alu_data_out !== 16'h8000 || zero_out !== 1'b0) begin
      errors++; $display("FAIL add_overflow: got %h/%b expected 8000/0", alu_data_out, zero_out);
    end
    checks++;
    if (stall_cycles != 0) begin errors++; $display("FAIL add_latency: got %0d stall cycles expected 0", stall_cycles); end
    issue(1, 4'd1, 3'd4, 3'd5, 16'd5, 16'd5, 0, 16'h0, 3'd3, 0, 0, 0);
    checks++;
    if (alu_data_out !== 16'h0000 || zero_out !== 1'b1) begin
      errors++; $display("FAIL sub_zero: got %h/%b expected 0000/1", alu_data_out, zero_out);
    end
    issue(1, 4'd7, 3'd4, 3'd5, 16'hFFFF, 16'h0001, 0, 16'h0, 3'd3, 0, 0, 0);
    checks++;
    if (alu_data_out !== 16'h0001) begin errors++; $display("FAIL slt_signed: got %h expected 0001", alu_data_out); end
    issue(1, 4'd5, 3'd4, 3'd5, 16'h0001, 16'h0, 1, 16'h0013, 3'd3, 0, 0, 0);
    checks++;
    if (alu_data_out !== 16'h0008) begin errors++; $display("FAIL shl_low_bits: got %h expected 0008", alu_data_out); end
  endtask

  task automatic test_forwarding();
    issue(1, 4'd0, 3'd4, 3'd5, 16'd3, 16'd4, 0, 16'h0, 3'd1, 1, 0, 0);
    wb_address = 3'd1; wb_en = 1; wb_data = 16'h0055;
    issue(1, 4'd0, 3'd1, 3'd1, 16'd0, 16'd0, 0, 16'h0, 3'd2, 1, 0, 0);
    checks++;
    if (alu_data_out !== 16'd14) begin errors++; $display("FAIL fwd_own_priority: got %h expected 000e", alu_data_out); end
    issue(1, 4'd0, 3'd1, 3'd6, 16'd0, 16'd0, 1, 16'h0, 3'd3, 1, 0, 0);
    checks++;
    if (alu_data_out !== 16'h0055) begin errors++; $display("FAIL fwd_writeback: got %h expected 0055", alu_data_out); end
    wb_en = 0;
  endtask

  task automatic test_mul();
    issue(1, 4'd8, 3'd4, 3'd5, 16'h0123, 16'h0010, 0, 16'h0, 3'd1, 1, 0, 0);
    checks++;
    if (stall_cycles != 16) begin errors++; $display("FAIL mul_stall_len: got %0d expected 16", stall_cycles); end
    checks++;
    if (bubble_bad !== 1'b0) begin errors++; $display("FAIL mul_bubbles: got %b expected 0", bubble_bad); end
    checks++;
    if (alu_data_out !== 16'h1230 || dut_vec !== exp_vec()) begin
      errors++; $display("FAIL mul_result: got %h expected %h", dut_vec, exp_vec());
    end
    issue(1, 4'd8, 3'd6, 3'd7, 16'hFFFF, 16'hFFFF, 0, 16'h0, 3'd2, 1, 0, 0);
    checks++;
    if (alu_data_out !== 16'h0001) begin errors++; $display("FAIL mul_wrap: got %h expected 0001", alu_data_out); end
  endtask

  task automatic test_store();
    issue(1, 4'd0, 3'd4, 3'd5, 16'h1000, 16'hBEEF, 1, 16'h0004, 3'd0, 0, 0, 1);
    checks++;
    if (we_out !== 1'b1 || store_data_out !== 16'hBEEF || alu_data_out !== 16'h1004) begin
      errors++; $display("FAIL store: got we=%b data=%h addr=%h expected 1/beef/1004", we_out, store_data_out, alu_data_out);
    end
  endtask

  task automatic test_reset_mid_mul();
    valid_in = 1; op = 4'd8; src_a_addr = 3'd4; src_b_addr = 3'd5; reg_a_data = 16'h0123;
    reg_b_data = 16'h0010; use_imm = 0; writeback_en_in = 1; writeback_address_in = 3'd1; we_in = 0;
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL mul_mid_stall: got %b expected 1", stall); end
    rst = 1; valid_in = 0;
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    checks++;
    if (stall !== 1'b0 || dut_vec !== 39'd1) begin
      errors++; $display("FAIL mul_abort: got stall=%b out=%h expected 0/%h", stall, dut_vec, 39'd1);
    end
    issue(1, 4'd0, 3'd4, 3'd5, 16'd2, 16'd3, 0, 16'h0, 3'd3, 1, 0, 0);
    checks++;
    if (stall_cycles != 0 || alu_data_out !== 16'd5) begin
      errors++; $display("FAIL add_after_abort: got %0d/%h expected 0/0005", stall_cycles, alu_data_out);
    end
  endtask

  task automatic test_random();
    logic v;
    logic [3:0] o;
    for (int i = 0; i < 300; i++) begin
      wb_en = 1'($urandom_range(0, 1));
      wb_address = 3'($urandom_range(0, 7));
      wb_data = 16'($urandom);
      v = ($urandom_range(0, 4) != 0);
      o = ($urandom_range(0, 7) == 0) ? 4'd8 : 4'($urandom_range(0, 15));
      issue(v, o, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom),
            1'($urandom_range(0, 1)), 16'($urandom), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL random_out[%0d]: got %h expected %h", i, dut_vec, exp_vec());
      end
      checks++;
      if (stall_cycles != ((v && o == 4'd8) ? 16 : 0) || bubble_bad !== 1'b0) begin
        errors++; $display("FAIL random_stall[%0d]: got %0d/%b expected %0d/0", i, stall_cycles, bubble_bad,
                           (v && o == 4'd8) ? 16 : 0);
      end
    end
    wb_en = 0;
  endtask

  initial begin
    test_reset();
    test_alu_basic();
    test_forwarding();
    test_mul();
    test_store();
    test_reset_mid_mul();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 Reset rst, synchronous, active-high; clock clk; all state updates on posedge clk.
REQ-002 clk  in  1  pipeline clock.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 valid_in  in  1  decode presents an instruction; 0 = bubble.
REQ-005 op  in  4  ALU opcode.
REQ-006 src_a_addr, src_b_addr  in  3 each  source register numbers, used for forwarding.
REQ-007 reg_a_data, reg_b_data  in  16 each  register-file read values.
REQ-008 use_imm  in  1  1 = operand B taken from imm.
REQ-009 imm  in  16  sign-extended immediate.
REQ-010 writeback_address_in  in  3, writeback_en_in  in  1, writeback_src_in  in  1 (0 = ALU, 1 = memory), we_in  in  1 (store).
REQ-011 wb_address, wb_en  in  3/1, and wb_data  in  16: final writeback-stage result, used for forwarding.
REQ-012 writeback_address_out  out  3, writeback_en_out  out  1, writeback_src_out  out  1: registered controls to the memory stage.
REQ-013 alu_data_out  out  16: registered ALU result, also used as the memory address.
REQ-014 store_data_out  out  16: registered, forwarded operand B value before the immediate mux; feeds memory write data.
REQ-015 we_out  out  1: registered memory write enable.
REQ-016 zero_out  out  1: registered, equals (result == 0).
REQ-017 stall  out  1: combinational; upstream holds all inputs while stall is high.

Function
REQ-018 Operand A = forward(src_a_addr, reg_a_data); raw B = forward(src_b_addr, reg_b_data); operand B = imm if use_imm, else raw B.
REQ-019 forward(s, r), highest priority first:
- Own output: alu_data_out if writeback_en_out and writeback_src_out==0 and writeback_address_out==s.
- Writeback: wb_data if wb_en and wb_address==s.
- Otherwise r.
- Register 0 has no special treatment.
REQ-020 Ops, 16-bit, with wrap-around:
- 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
- 5 SHL by B[3:0], 6 logical SHR by B[3:0].
- 7 SLT signed: result 1 or 0.
- 8 MUL: low 16 bits of the product, multi-cycle.
- 9-15 pass B.
REQ-021 Single-cycle ops: stall=0; results and controls register at the next edge (latency 1).
REQ-022 Bubble (valid_in=0, not stalled): the next edge loads writeback_en_out=0, we_out=0, and zeros into all other outputs except zero_out, which is 1.
REQ-023 FSM states are IDLE and MUL; reset state is IDLE.
REQ-024 In IDLE with valid_in and op==8:
- stall=1.
- At the edge, latch A, B, raw B and the instruction controls, clear the product and cnt (4 bits), and go to MUL.
- Output registers load a bubble.
REQ-025 In MUL, each edge does one shift-add iteration and cnt+1:
- If multiplier bit cnt is set, the product gains the multiplicand shifted left by cnt.
REQ-026 In MUL, stall=1 while cnt<15. With cnt==15, stall=0 and the edge:
- performs the final iteration,
- registers the product with the latched controls,
- returns to IDLE.
REQ-027 MUL occupies 17 cycles: stall is high for 16 cycles, and the result is visible the cycle after release.
REQ-028 In MUL, inputs other than rst are ignored; output registers hold a bubble until completion.
REQ-029 Load-use hazards (consumer of writeback_src_out==1) are resolved upstream; no interlock exists in this block.

Reset
REQ-030 On rst, at the edge:
- all output registers are set to 0, except zero_out, which is set to 1;
- the FSM goes to IDLE, cnt to 0, and the latched operands to 0.
REQ-031 Reset during MUL abandons the multiply; stall=0 in the cycle after reset.
REQ-032 rst has priority over valid_in and FSM activity.

Verification
REQ-033 Directed scenarios:
- ADD: A=0x7FFF, B=0x0001 -> next cycle alu_data_out=0x8000, zero_out=0. SUB: 5-5 -> alu_data_out=0, zero_out=1.
- Forwarding: ADD r1=3+4, then ADD r2=r1+r1 with stale reg_a_data=0 -> alu_data_out=14. With both own-output and wb matching r1, own-output wins.
- SLT: 0xFFFF vs 0x0001 -> 1. SHL: 0x0001 by 0x0013 -> 0x0008 (B[3:0]=3).
- MUL: 0x0123*0x0010 -> stall high exactly 16 cycles, then alu_data_out=0x1230. 0xFFFF*0xFFFF -> 0x0001. Bubbles on outputs during the multiply.
- Store: we_in=1, use_imm=1, imm=0x0004, reg_b_data=0xBEEF -> we_out=1, store_data_out=0xBEEF, alu_data_out=A+4.
- rst asserted at MUL cnt=7 -> next cycle stall=0, outputs reset. A following ADD completes in 1 cycle.
